ad1939_dac_serializer: RTL

Transmit-side counterpart of the AD1939 ADC capture path. The block accepts left/right audio samples from the fabric on an Avalon-ST sink and serializes them as I2S onto the AD1939 DAC pins (dsdata1, dbclk, dlrclk). It generates DAC bit and frame clocks internally by dividing the codec master clock, so the whole block runs in a single clock domain. It sits between the audio processing chain and the ad1939_physical DAC conduit.

---
 rtl/ad1939_dac_serializer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ad1939_dac_serializer.sv
// I2S serializer for the AD1939 DAC: Avalon-ST left/right sink, internally
// divided bit/frame clocks, double-buffered sample pair with underflow repeat.
module ad1939_dac_serializer #(
    parameter int DATA_W   = 24,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] avalon_st_sink_data,
    input  logic              avalon_st_sink_channel,
    input  logic              avalon_st_sink_valid,
    output logic              avalon_st_sink_ready,
    output logic              dsdata1,
    output logic              dbclk,
    output logic              dlrclk,
    output logic              underflow,
    output logic              overrun
);

    localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_W);

    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_next;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_next;
    logic [BIT_W-1:0]  pos;
    logic              bit_tick;
    logic              frame_start;
    logic              right_slot;
    logic              data_bit;
    logic              accept;

    logic              left_full;
    logic              right_full;
    logic [DATA_W-1:0] left_hold;
    logic [DATA_W-1:0] right_hold;
    logic [DATA_W-1:0] left_shift;
    logic [DATA_W-1:0] right_shift;
    logic [DATA_W-1:0] last_left;
    logic [DATA_W-1:0] last_right;

    always_comb begin
        bit_tick    = (div_cnt == DIV_W'(BCLK_DIV - 1));
        div_next    = bit_tick ? '0 : div_cnt + 1'b1;
        frame_start = bit_tick && (bit_cnt == BIT_W'(2 * SLOT_W - 1));
        bit_next    = bit_cnt;
        if (bit_tick) begin
            bit_next = frame_start ? '0 : bit_cnt + 1'b1;
        end
        // Slot position of the bit being launched at this tick.
        right_slot  = (bit_next >= BIT_W'(SLOT_W));
        pos         = right_slot ? bit_next - BIT_W'(SLOT_W) : bit_next;
        data_bit    = (pos != '0) && (pos <= BIT_W'(DATA_W));
        avalon_st_sink_ready = !(left_full && right_full);
        accept      = avalon_st_sink_valid && avalon_st_sink_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt     <= '0;
            bit_cnt     <= '0;
            dbclk       <= 1'b0;
            dlrclk      <= 1'b0;
            dsdata1     <= 1'b0;
            underflow   <= 1'b0;
            overrun     <= 1'b0;
            left_full   <= 1'b0;
            right_full  <= 1'b0;
            left_hold   <= '0;
            right_hold  <= '0;
            left_shift  <= '0;
            right_shift <= '0;
            last_left   <= '0;
            last_right  <= '0;
        end else begin
            div_cnt   <= div_next;
            dbclk     <= (div_next >= DIV_W'(BCLK_DIV / 2));
            underflow <= 1'b0;
            overrun   <= 1'b0;

            if (bit_tick) begin
                bit_cnt <= bit_next;
                dlrclk  <= right_slot;
                dsdata1 <= 1'b0;
                if (frame_start) begin
                    if (left_full && right_full) begin
                        left_shift  <= left_hold;
                        right_shift <= right_hold;
                        last_left   <= left_hold;
                        last_right  <= right_hold;
                        left_full   <= 1'b0;
                        right_full  <= 1'b0;
                    end else begin
                        left_shift  <= last_left;
                        right_shift <= last_right;
                        underflow   <= 1'b1;
                    end
                end else if (data_bit) begin
                    if (right_slot) begin
                        dsdata1     <= right_shift[DATA_W-1];
                        right_shift <= {right_shift[DATA_W-2:0], 1'b0};
                    end else begin
                        dsdata1     <= left_shift[DATA_W-1];
                        left_shift  <= {left_shift[DATA_W-2:0], 1'b0};
                    end
                end
            end

            // Accept lands after any frame-start transfer above, so its flag wins.
            if (accept) begin
                if (avalon_st_sink_channel) begin
                    right_hold <= avalon_st_sink_data;
                    right_full <= 1'b1;
                    overrun    <= right_full;
                end else begin
                    left_hold  <= avalon_st_sink_data;
                    left_full  <= 1'b1;
                    overrun    <= left_full;
                end
            end
        end
    end

endmodule
